// File: rtl/a0_trace_fifo.sv
// a0 change-trace FIFO.
// Watches the core's a0 result and records every change of value into a
// show-ahead FIFO. A host consumer drains it over a valid/ready handshake.
// Captures that arrive while the FIFO is full are dropped, and each drop is
// flagged (sticky overflow) and counted (saturating drop_count).
module a0_trace_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int DROP_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a0,
    input  logic                  en,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W:0]       count,
    output logic                  full,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_count
);

    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wrPtr;
    logic [ADDR_W-1:0]     rdPtr;
    logic [ADDR_W:0]       countQ;
    logic                  overflowQ;
    logic [DROP_W-1:0]     dropCnt;
    logic [DATA_WIDTH-1:0] prevA0;
    logic                  prevValid;

    logic captureEvent;
    logic popDo;
    logic pushOk;
    logic dropDo;

    // Change detection and push/pop arbitration; a pop frees a slot for a
    // same-cycle push, so a full FIFO keeps accepting while it is drained.
    always_comb begin
        captureEvent = en && (!prevValid || (a0 != prevA0));
        popDo        = (countQ != '0) && out_ready;
        pushOk       = captureEvent && ((countQ != FullCount) || popDo);
        dropDo       = captureEvent && !pushOk;
    end

    // Pointers, occupancy, drop bookkeeping and change history.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            countQ    <= '0;
            overflowQ <= 1'b0;
            dropCnt   <= '0;
            prevA0    <= '0;
            prevValid <= 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popDo) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushOk, popDo})
                2'b10:   countQ <= countQ + 1'b1;
                2'b01:   countQ <= countQ - 1'b1;
                default: countQ <= countQ;
            endcase
            if (dropDo) begin
                overflowQ <= 1'b1;
                if (dropCnt != '1) begin
                    dropCnt <= dropCnt + 1'b1;
                end
            end
            // History follows a0 even on a drop so a held value is not retried.
            if (en) begin
                prevA0    <= a0;
                prevValid <= 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care after reset since the pointers restart.
    always_ff @(posedge clk) begin
        if (rst && !clear && pushOk) begin
            mem[wrPtr] <= a0;
        end
    end

    // Outputs depend on registered state only; head is forced to zero when empty.
    always_comb begin
        out_valid  = (countQ != '0);
        out_data   = out_valid ? mem[rdPtr] : '0;
        count      = countQ;
        full       = (countQ == FullCount);
        overflow   = overflowQ;
        drop_count = dropCnt;
    end

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Bench for a0_trace_fifo: a reference queue model scoreboards every cycle,
// a vector table covers the basic capture/drain patterns, and short
// hand-written sequences cover overflow, full push+pop, wrap and reset.
module tb_a0_trace_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] a0;
    logic        en;
    logic        clear;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  count;
    logic        full;
    logic        overflow;
    logic [15:0] drop_count;

    a0_trace_fifo #(
        .DATA_WIDTH(32), .DEPTH(16), .ADDR_W(4), .DROP_W(16)
    ) dut (
        .clk(clk), .rst(rst), .a0(a0), .en(en), .clear(clear),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .overflow(overflow), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;

    // Reference model state.
    logic [31:0] mq[$];
    logic [31:0] readback[$];
    logic [31:0] mPrev;
    bit          mPrevValid;
    bit          mOvf;
    int          mDrop;

    typedef struct {
        logic [31:0] a0;
        bit          en;
        bit          rdy;
        bit          clr;
        int          expCount;
        bit          expValid;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic modelReset();
        mq.delete();
        mPrev      = '0;
        mPrevValid = 1'b0;
        mOvf       = 1'b0;
        mDrop      = 0;
    endtask

    // Compare DUT outputs against the model, advance the model by one edge
    // using the currently driven inputs, then step past the edge.
    task automatic cycle();
        bit ev;
        bit pop;
        chk("count", count, mq.size());
        chk("out_valid", out_valid, mq.size() != 0);
        chk("full", full, mq.size() == 16);
        chk("overflow", overflow, mOvf);
        chk("drop_count", drop_count, mDrop);
        chk("out_data", out_data, (mq.size() != 0) ? mq[0] : 32'h0);
        if (!rst || clear) begin
            modelReset();
        end else begin
            ev  = en && (!mPrevValid || (a0 != mPrev));
            pop = (mq.size() != 0) && out_ready;
            if (pop) begin
                readback.push_back(out_data);
                void'(mq.pop_front());
            end
            if (ev) begin
                if (mq.size() < 16) mq.push_back(a0);
                else begin
                    mOvf = 1'b1;
                    if (mDrop < 65535) mDrop++;
                end
            end
            if (en) begin
                mPrev      = a0;
                mPrevValid = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doClear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b0; a0 = '0; en = 1'b0; clear = 1'b0; out_ready = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        // Reset state (rst still low for this edge too).
        cycle();
        rst = 1'b1;

        // Held zero captured once; clear; then 5,5,7,7,7,9 and drain.
        for (int i = 0; i < 5; i++) vecs.push_back('{32'h0, 1, 0, 0, 1, 1, 32'h0});
        vecs.push_back('{32'h0, 1, 0, 1, 0, 0, 32'h0});
        vecs.push_back('{32'd5, 1, 0, 0, 1, 1, 32'd5});
        vecs.push_back('{32'd5, 1, 0, 0, 1, 1, 32'd5});
        vecs.push_back('{32'd7, 1, 0, 0, 2, 1, 32'd5});
        vecs.push_back('{32'd7, 1, 0, 0, 2, 1, 32'd5});
        vecs.push_back('{32'd7, 1, 0, 0, 2, 1, 32'd5});
        vecs.push_back('{32'd9, 1, 0, 0, 3, 1, 32'd5});
        vecs.push_back('{32'd9, 1, 1, 0, 2, 1, 32'd7});
        vecs.push_back('{32'd9, 1, 1, 0, 1, 1, 32'd9});
        vecs.push_back('{32'd9, 1, 1, 0, 0, 0, 32'h0});
        foreach (vecs[i]) begin
            a0 = vecs[i].a0; en = vecs[i].en; out_ready = vecs[i].rdy; clear = vecs[i].clr;
            cycle();
            chk($sformatf("vec%0d_count", i), count, vecs[i].expCount);
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].expValid);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].expData);
        end
        clear = 1'b0; out_ready = 1'b0;

        // Overflow: 20 changing values into 16 slots.
        doClear();
        en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            a0 = i;
            cycle();
        end
        en = 1'b0;
        chk("ovf_count", count, 16);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_count, 4);
        for (int i = 1; i <= 16; i++) begin
            chk("ovf_drain", out_data, i);
            out_ready = 1'b1;
            cycle();
        end
        out_ready = 1'b0;
        chk("ovf_empty", out_valid, 0);
        doClear();
        chk("clr_count", count, 0);
        chk("clr_flag", overflow, 0);
        chk("clr_drops", drop_count, 0);

        // Full FIFO with simultaneous push and pop.
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a0 = 32'h100 + i;
            cycle();
        end
        chk("fp_full_before", full, 1);
        a0 = 32'hABCD; out_ready = 1'b1;
        cycle();
        chk("fp_count", count, 16);
        chk("fp_drops", drop_count, 0);
        chk("fp_head", out_data, 32'h101);
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("fp_last", out_data, 32'hABCD);
            cycle();
        end
        out_ready = 1'b0;
        chk("fp_empty", count, 0);

        // Pointer wrap: 40 distinct values with interleaved consumer stalls.
        doClear();
        readback.delete();
        for (int i = 0; i < 80; i++) begin
            en = 1'b1;
            a0 = 32'd1000 + 32'(i / 2);
            out_ready = (i % 3) != 0;
            cycle();
        end
        en = 1'b0; out_ready = 1'b1;
        repeat (20) cycle();
        out_ready = 1'b0;
        chk("wrap_n", readback.size(), 40);
        for (int k = 0; k < readback.size() && k < 40; k++)
            chk($sformatf("wrap_%0d", k), readback[k], 32'd1000 + 32'(k));
        chk("wrap_drops", drop_count, 0);
        chk("wrap_count", count, 0);

        // Reset mid-operation, then recapture of the pre-reset value.
        doClear();
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a0 = 32'd77 + i;
            cycle();
        end
        en = 1'b0;
        chk("rst_pre_count", count, 6);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        en = 1'b1; a0 = 32'd82;
        cycle();
        en = 1'b0;
        chk("rst_recap_count", count, 1);
        chk("rst_recap_data", out_data, 32'd82);
        cycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
